// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a built-in test-pattern source.
// Counters are exposed directly; syncs, de, colour and frame_start are registered one ce-cycle later.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CBITS      = 4,
    parameter int CHECK_LOG2 = 5,
    parameter logic [3*CBITS-1:0] SOLID_RGB = '1,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [1:0]         mode,
    input  logic [3*CBITS-1:0] rgb_in,
    output logic [XW-1:0]      pixel_x,
    output logic [YW-1:0]      pixel_y,
    output logic [3*CBITS-1:0] rgb_out,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);
    localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [XW-1:0]      h;
    logic [YW-1:0]      v;
    logic [1:0]         mode_q;
    logic [XW-1:0]      bpix;
    logic [2:0]         bar;

    logic               h_last, v_last, at_origin, active, hs_on, vs_on, chk;
    logic [1:0]         eff_mode;
    logic [2:0]         code;
    logic [CBITS-1:0]   full;
    logic [3*CBITS-1:0] bar_rgb, pix_rgb;

    assign pixel_x = h;
    assign pixel_y = v;

    always_comb begin
        h_last    = (32'(h) == H_TOTAL - 1);
        v_last    = (32'(v) == V_TOTAL - 1);
        at_origin = (h == '0) && (v == '0);
        // The origin pixel already belongs to the new frame, so it sees the incoming mode.
        eff_mode  = at_origin ? mode : mode_q;
        active    = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hs_on     = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
        vs_on     = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
        chk       = (|((h >> CHECK_LOG2) & XW'(1))) ^ (|((v >> CHECK_LOG2) & YW'(1)));
        full      = '1;
        code      = 3'd7 - bar;
        bar_rgb   = {code[1] ? full : {CBITS{1'b0}},
                     code[2] ? full : {CBITS{1'b0}},
                     code[0] ? full : {CBITS{1'b0}}};
        pix_rgb   = '0;
        if (active) begin
            case (eff_mode)
                2'b00:   pix_rgb = rgb_in;
                2'b01:   pix_rgb = bar_rgb;
                2'b10:   pix_rgb = chk ? '1 : '0;
                default: pix_rgb = SOLID_RGB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            mode_q      <= mode;
            bpix        <= '0;
            bar         <= '0;
            rgb_out     <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
        end else if (ce) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + YW'(1);
            end else begin
                h <= h + XW'(1);
            end
            if (at_origin)
                mode_q <= mode;
            // Bar state tracks the pixel held in h; it restarts as the line wraps.
            if (h_last) begin
                bpix <= '0;
                bar  <= '0;
            end else if (32'(bpix) == BW - 1) begin
                bpix <= '0;
                if (bar != 3'd7)
                    bar <= bar + 3'd1;
            end else begin
                bpix <= bpix + XW'(1);
            end
            rgb_out     <= pix_rgb;
            de          <= active;
            frame_start <= at_origin;
            hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a 16x8 raster, checked against a coordinate-level model.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset, ce;
    logic [1:0]  mode;
    logic [11:0] rgb_in;
    logic [3:0]  pixel_x;
    logic [2:0]  pixel_y;
    logic [11:0] rgb_out;
    logic        hsync, vsync, de, frame_start;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CBITS(4), .CHECK_LOG2(1)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .rgb_in(rgb_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int hm, vm, n_fs, n_de;
    logic [1:0]  fmode;
    logic [11:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int x, input int y, input logic [1:0] md,
                                        input logic [11:0] rin);
        int k;
        logic [2:0] c;
        if (!(x < HA && y < VA)) return 12'h000;
        case (md)
            2'd0: return rin;
            2'd1: begin
                k = x / (HA / 8);
                if (k > 7) k = 7;
                c = 3'(7 - k);
                return {c[1] ? 4'hF : 4'h0, c[2] ? 4'hF : 4'h0, c[0] ? 4'hF : 4'h0};
            end
            2'd2: return (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 12'hFFF : 12'h000;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic step(input logic r, input logic c, input logic [1:0] m, input logic [11:0] rin);
        reset = r; ce = c; mode = m; rgb_in = rin;
        if (r) begin
            hm = 0; vm = 0; fmode = m;
            e_rgb = 12'h000; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0;
        end else if (c) begin
            if (hm == 0 && vm == 0) fmode = m;
            e_de  = (hm < HA) && (vm < VA);
            e_rgb = pix(hm, vm, fmode, rin);
            e_hs  = !(hm >= HA + HF && hm < HA + HF + HS);
            e_vs  = !(vm >= VA + VF && vm < VA + VF + VS);
            e_fs  = (hm == 0 && vm == 0);
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm = (vm + 1) % VT;
            end
        end
        @(posedge clk);
        #1;
        chk("pixel_x", 32'(pixel_x), 32'(hm));
        chk("pixel_y", 32'(pixel_y), 32'(vm));
        chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
        chk("de", 32'(de), 32'(e_de));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        if (frame_start) n_fs++;
        if (de) n_de++;
    endtask

    initial begin
        int guard;
        reset = 1; ce = 0; mode = 0; rgb_in = 0;
        step(1, 1, 2'd3, 12'h0);
        step(1, 0, 2'd3, 12'h0);

        // Solid colour, two full frames from the origin.
        n_fs = 0; n_de = 0;
        repeat (256) step(0, 1, 2'd3, 12'($urandom));
        chk("fs_count", 32'(n_fs), 32'd2);
        chk("de_count", 32'(n_de), 32'd64);

        // External source: pixel derived from the coordinate.
        repeat (128) step(0, 1, 2'd0, {4'(hm), 4'(vm), 4'h5});
        // Colour bars.
        repeat (128) step(0, 1, 2'd1, 12'($urandom));
        // Mid-frame switch solid -> checkerboard.
        repeat (128) step(0, 1, (vm >= 2) ? 2'd2 : 2'd3, 12'($urandom));
        repeat (128) step(0, 1, 2'd2, 12'($urandom));

        // Gappy clock enable with random modes.
        repeat (600) step(0, 1'($urandom_range(0, 1)), 2'($urandom), 12'($urandom));

        // Reset mid-frame at (5,2).
        guard = 0;
        while (!(hm == 5 && vm == 2) && guard < 300) begin
            step(0, 1, 2'd3, 12'($urandom));
            guard++;
        end
        chk("reach_5_2", 32'(guard < 300), 32'd1);
        step(1, 1, 2'd3, 12'h0);
        step(0, 0, 2'd3, 12'h0);
        step(0, 1, 2'd3, 12'h0);
        chk("rst_fs", 32'(frame_start), 32'd1);
        chk("rst_de", 32'(de), 32'd1);

        // Random resets sprinkled over random traffic.
        repeat (300) step(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) != 0),
                          2'($urandom), 12'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameters V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical equivalents in lines.
REQ-004 Parameters HSYNC_POL / VSYNC_POL, 0 / 0, sync active level (0 = active-low).
REQ-005 Parameter CBITS, 4, bits per colour channel; RGB word is {R,G,B}, 3*CBITS wide.
REQ-006 Parameter CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels.
REQ-007 Parameter SOLID_RGB, all ones, colour for solid mode.
REQ-008 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL).
REQ-009 clk  in  1  pixel-domain clock.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 ce  in  1  pixel clock enable; all state advances only when high.
REQ-012 mode  in  2  source select: 00 external, 01 colour bars, 10 checkerboard, 11 solid.
REQ-013 rgb_in  in  3*CBITS  external pixel for current pixel_x/pixel_y.
REQ-014 pixel_x  out  XW  current horizontal counter (request coordinate).
REQ-015 pixel_y  out  YW  current vertical counter.
REQ-016 rgb_out  out  3*CBITS  registered pixel colour.
REQ-017 hsync, vsync  out  1 each  registered sync outputs.
REQ-018 de  out  1  registered display-enable.
REQ-019 frame_start  out  1  one-cycle pulse aligned with first active pixel of a frame.

Function
REQ-020 h counter counts 0..H_TOTAL-1 on each ce cycle, wraps to 0; v counter increments on each h wrap, counts 0..V_TOTAL-1, wraps to 0 when h and v wrap together.
REQ-021 Region order per axis: active [0,ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
REQ-022 pixel_x/pixel_y equal the counters directly (zero latency).
REQ-023 hsync/vsync/de/rgb_out/frame_start are registered: values for counter (h,v) appear one ce-cycle after the counter holds (h,v) — latency 1.
REQ-024 de = 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-025 hsync = HSYNC_POL while h in horizontal sync range, else ~HSYNC_POL; vsync likewise on v, changing only at h wrap.
REQ-026 rgb_out = 0 whenever the corresponding de is 0, regardless of mode.
REQ-027 Mode 00: rgb_out = rgb_in sampled in the cycle pixel_x/pixel_y present the coordinate.
REQ-028 Mode 01: 8 vertical bars, width BW = H_ACTIVE/8 (integer), tracked by a sequential bar-pixel counter and 3-bit bar index cleared at h=0; bar k>7 (remainder pixels) treated as k=7; colour code c = 7-k, R full if c[1], G full if c[2], B full if c[0] (white, yellow, cyan, green, magenta, red, blue, black).
REQ-029 Mode 10: white if x[CHECK_LOG2] XOR y[CHECK_LOG2], else black.
REQ-030 Mode 11: SOLID_RGB.
REQ-031 mode is latched into an internal register only when counter is (0,0) and ce is high; mid-frame mode changes take effect at the next frame.
REQ-032 frame_start = 1 for exactly the output cycle corresponding to (0,0); 0 otherwise.
REQ-033 ce low: counters, latched mode, bar state and all registered outputs hold their values.

Reset
REQ-034 On reset high at a clk edge (independent of ce): h=v=0, bar state 0, latched mode = mode input, de=0, rgb_out=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-035 Reset asserted mid-frame aborts the frame; first ce cycle after release outputs (0,0) values with frame_start=1.

Verification
REQ-036 Small params H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), ce=1, mode=11 -> de high 8 of 16 cycles for lines 0..3, hsync low output cycles for h=10..12, vsync low for lines 5..6, frame period 128 cycles, frame_start every 128.
REQ-037 Same params, mode=00, rgb_in = {pixel_x[3:0], pixel_y[3:0], 4'h5} -> rgb_out one cycle later matches coordinate during de, 0 during blanking.
REQ-038 mode=01, H_ACTIVE=8 (BW=1) -> active line outputs FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-039 Switch mode 11->10 at v=2 -> remainder of frame stays SOLID_RGB; checkerboard from next frame_start.
REQ-040 ce toggled 1-0-1 pattern -> outputs identical to ce=1 run sampled on ce cycles; no change while ce low.
REQ-041 Reset pulsed at (h=5,v=2) -> outputs take reset values next cycle; after release frame_start and de=1 on first ce cycle.
